board_check_seq: RTL and testbench
==================================

Name: board_check_seq

Overview:
- Sequencer for the board-check datapath, started by the main controller's check_flag when it enters CHECKING.
- Scans all 81 cells of the player board RAM and the solution RAM in lockstep, one read per cycle with 1-cycle read latency.
- Compares each cell pair and accumulates empty and mismatch counts.
- Returns a one-cycle done pulse and a solved verdict that feed the main controller's solved input.

Parameters:
- CELLS, 81, number of board cells scanned (addresses 0..CELLS-1).
- ADDR_W, 7, RAM address width; must satisfy 2^ADDR_W >= CELLS.
- VAL_W, 4, cell value width; value 0 = empty, 1..9 = digit.

Ports:
- clka  in  1  single system clock; all state changes on its rising edge.
- restart_n  in  1  synchronous active-low reset, sampled on the clka rising edge.
- start  in  1  check request, level from check_flag; acted on only in IDLE.
- rd_en  out  1  read strobe to both RAMs.
- rd_addr  out  ADDR_W  shared cell address to both RAMs.
- board_q  in  VAL_W  player board RAM data, valid the cycle after rd_en.
- sol_q  in  VAL_W  solution RAM data, valid the cycle after rd_en.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- solved  out  1  1 when every cell is filled and matches the solution.
- empty_cnt  out  ADDR_W  number of cells with board value 0.
- err_cnt  out  ADDR_W  number of non-empty cells not equal to the solution.
- first_err  out  ADDR_W  lowest address with a mismatch; all-ones if none.

Behaviour:
- Reset (restart_n=0 at an edge), regardless of state:
  - state=IDLE; rd_en=0, rd_addr=0, busy=0, done=0, solved=0.
  - empty_cnt=0, err_cnt=0, first_err=all-ones.
  - Reset mid-scan abandons the scan; no done pulse is issued.
- States: IDLE, SCAN, DRAIN, DONE, WAIT_LOW.
- IDLE:
  - start=1 -> SCAN. Clear counters, set first_err=all-ones, rd_addr=0, rd_en=1, busy=1.
  - Previous results hold until this acceptance edge.
- SCAN:
  - Each cycle rd_addr increments by 1 and rd_en stays 1.
  - From the second SCAN cycle on, the edge compares the data for rd_addr-1.
  - Leaving SCAN when rd_addr=CELLS-1 -> DRAIN with rd_en=0.
  - Cycle k after acceptance (k=0..80) presents address k; the compare for cell k occurs at the end of cycle k+1.
- DRAIN: compares cell CELLS-1 -> DONE.
- Compare rule for a cell pair (b, s):
  - b==0: empty_cnt+1.
  - b!=0 and b!=s: err_cnt+1; if first_err is all-ones, first_err = cell address.
  - Otherwise no change.
  - Counts cannot overflow (max 81 < 128); no saturation logic.
- DONE: lasts exactly one cycle (cycle 82 after acceptance).
  - done=1, busy=0.
  - solved = (empty_cnt==0 && err_cnt==0), computed from the final counts including cell 80.
  - -> WAIT_LOW.
- WAIT_LOW:
  - Stays while start=1, so a level-held check_flag triggers only one scan.
  - start=0 -> IDLE.
- start is ignored in SCAN, DRAIN and DONE. No restart of a scan without reset.
- solved, empty_cnt, err_cnt and first_err are registered and hold their last values through WAIT_LOW and IDLE.
- rd_addr holds its last value when rd_en=0. RAM outputs are don't-care when rd_en=0 and are never compared.
- Total latency: acceptance edge to done pulse = 82 cycles.

Decomposition:
- Package sudoku_pkg holds:
  - CELLS, ADDR_W, VAL_W, EMPTY_VAL=0, NO_ERR=all-ones.
  - Sequencer state encodings: IDLE=0, SCAN=1, DRAIN=2, DONE=3, WAIT_LOW=4; 3-bit.
- One natural sub-module: cell_cmp_acc, the compare/accumulate stage.
  - Inputs: valid, addr, board_q, sol_q, clear.
  - Outputs: empty_cnt, err_cnt, first_err.
  - The sequencer owns the FSM and address counter, and drives valid as a 1-cycle-delayed rd_en.

Test Plan:
- Board == solution, all filled; start held high 100 cycles -> exactly one done pulse at cycle 82; solved=1, empty_cnt=0, err_cnt=0, first_err=127; no second scan until start drops.
- Board == solution except cell 5 = 0 and cell 40 = 0 -> solved=0, empty_cnt=2, err_cnt=0, first_err=127.
- Cell 80 board=3 vs solution 7, cell 12 board=1 vs 2 -> err_cnt=2, first_err=12, solved=0; confirms the last cell is compared in DRAIN.
- restart_n=0 at cycle 30 of a scan -> next cycle state IDLE, busy=0, rd_en=0, counters cleared, no done pulse; a fresh start gives correct results.
- rd_addr trace -> 0,1,...,80 on consecutive cycles with rd_en=1, then rd_en=0; no address >= 81 is ever strobed.
- Back-to-back checks with the board changed between them -> second done reflects the new board; results from the first run hold until the second acceptance edge.

Source files
------------

// File: rtl/sudoku_pkg.sv
// -----------------------------------------------------------------------------
// sudoku_pkg
// Shared constants for the board-check datapath: board geometry, RAM widths,
// the empty-cell marker, the "no mismatch" marker and the sequencer state
// encodings used by board_check_seq.
// -----------------------------------------------------------------------------
package sudoku_pkg;

    localparam int CELLS  = 81;
    localparam int ADDR_W = 7;
    localparam int VAL_W  = 4;

    localparam logic [VAL_W-1:0]  EMPTY_VAL = '0;
    localparam logic [ADDR_W-1:0] NO_ERR    = '1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    // Sequencer state encodings
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SCAN     = 3'd1;
    localparam logic [2:0] ST_DRAIN    = 3'd2;
    localparam logic [2:0] ST_DONE     = 3'd3;
    localparam logic [2:0] ST_WAIT_LOW = 3'd4;

    // A cell is good when it is filled and agrees with the solution.
    function automatic logic cell_ok(input logic [VAL_W-1:0] b,
                                     input logic [VAL_W-1:0] s);
        return (b != EMPTY_VAL) && (b == s);
    endfunction

endpackage

// File: rtl/cell_cmp_acc.sv
// -----------------------------------------------------------------------------
// cell_cmp_acc
// Compare/accumulate stage of the board check. Each cycle with valid=1 it
// compares one board/solution cell pair and updates the empty count, the
// mismatch count and the lowest mismatching address.
//
// Ports:
//   clka      in   system clock
//   restart_n in   synchronous active-low reset
//   clear     in   synchronous clear of all results (new scan accepted)
//   valid     in   board_q/sol_q/addr describe a cell to compare
//   addr      in   address of the cell being compared
//   board_q   in   player board value
//   sol_q     in   solution value
//   empty_cnt out  number of empty cells seen
//   err_cnt   out  number of filled cells that disagree with the solution
//   first_err out  lowest mismatching address, all-ones if none
// -----------------------------------------------------------------------------
module cell_cmp_acc
    import sudoku_pkg::*;
(
    input  logic              clka,
    input  logic              restart_n,
    input  logic              clear,
    input  logic              valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [VAL_W-1:0]  board_q,
    input  logic [VAL_W-1:0]  sol_q,
    output logic [ADDR_W-1:0] empty_cnt,
    output logic [ADDR_W-1:0] err_cnt,
    output logic [ADDR_W-1:0] first_err
);

    always_ff @(posedge clka) begin
        if (!restart_n || clear) begin
            empty_cnt <= '0;
            err_cnt   <= '0;
            first_err <= NO_ERR;
        end else if (valid) begin
            if (board_q == EMPTY_VAL) begin
                empty_cnt <= empty_cnt + ADDR_W'(1);
            end else if (board_q != sol_q) begin
                err_cnt <= err_cnt + ADDR_W'(1);
                // Cells arrive in ascending order, so the first capture is the lowest.
                if (first_err == NO_ERR) begin
                    first_err <= addr;
                end
            end
        end
    end

endmodule

// File: rtl/board_check_seq.sv
// -----------------------------------------------------------------------------
// board_check_seq
// Board-check sequencer. On a start request it reads all CELLS cells of the
// player board RAM and the solution RAM in lockstep (1-cycle read latency),
// compares each pair and reports a one-cycle done pulse with a solved verdict
// and empty/mismatch statistics.
//
// Ports:
//   clka      in   system clock
//   restart_n in   synchronous active-low reset
//   start     in   check request level, acted on only in IDLE
//   rd_en     out  read strobe to both RAMs
//   rd_addr   out  shared cell address to both RAMs
//   board_q   in   board RAM data, valid the cycle after rd_en
//   sol_q     in   solution RAM data, valid the cycle after rd_en
//   busy      out  high from start acceptance until done
//   done      out  one-cycle completion pulse
//   solved    out  every cell filled and matching the solution
//   empty_cnt out  number of empty cells
//   err_cnt   out  number of filled cells not matching the solution
//   first_err out  lowest mismatching address, all-ones if none
// -----------------------------------------------------------------------------
module board_check_seq
    import sudoku_pkg::*;
(
    input  logic              clka,
    input  logic              restart_n,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [VAL_W-1:0]  board_q,
    input  logic [VAL_W-1:0]  sol_q,
    output logic              busy,
    output logic              done,
    output logic              solved,
    output logic [ADDR_W-1:0] empty_cnt,
    output logic [ADDR_W-1:0] err_cnt,
    output logic [ADDR_W-1:0] first_err
);

    logic [2:0]        state;
    logic              valid_q;
    logic [ADDR_W-1:0] cmp_addr_q;
    logic              accept;

    assign accept = (state == ST_IDLE) && start;
    assign busy   = (state == ST_SCAN) || (state == ST_DRAIN);
    assign done   = (state == ST_DONE);

    always_ff @(posedge clka) begin
        if (!restart_n) begin
            state      <= ST_IDLE;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            valid_q    <= 1'b0;
            cmp_addr_q <= '0;
            solved     <= 1'b0;
        end else begin
            // Read data for the address strobed this cycle is compared next cycle.
            valid_q    <= rd_en;
            cmp_addr_q <= rd_addr;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_SCAN;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        solved  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (rd_addr == LAST_ADDR) begin
                        state <= ST_DRAIN;
                        rd_en <= 1'b0;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // The last cell is accumulated on this same edge, so fold
                    // its verdict in directly rather than waiting a cycle.
                    state  <= ST_DONE;
                    solved <= (empty_cnt == '0) && (err_cnt == '0) &&
                              cell_ok(board_q, sol_q);
                end
                ST_DONE: begin
                    state <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!start) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    rd_en <= 1'b0;
                end
            endcase
        end
    end

    cell_cmp_acc u_cmp (
        .clka      (clka),
        .restart_n (restart_n),
        .clear     (accept),
        .valid     (valid_q),
        .addr      (cmp_addr_q),
        .board_q   (board_q),
        .sol_q     (sol_q),
        .empty_cnt (empty_cnt),
        .err_cnt   (err_cnt),
        .first_err (first_err)
    );

endmodule

// File: tb/tb_board_check_seq.sv
// -----------------------------------------------------------------------------
// tb_board_check_seq
// Self-checking bench for board_check_seq with a behavioural pair of RAMs.
// -----------------------------------------------------------------------------
module tb_board_check_seq;
    import sudoku_pkg::*;

    logic              clka = 1'b0;
    logic              restart_n;
    logic              start;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [VAL_W-1:0]  board_q;
    logic [VAL_W-1:0]  sol_q;
    logic              busy;
    logic              done;
    logic              solved;
    logic [ADDR_W-1:0] empty_cnt;
    logic [ADDR_W-1:0] err_cnt;
    logic [ADDR_W-1:0] first_err;

    always #5 clka = ~clka;

    board_check_seq dut (
        .clka      (clka),
        .restart_n (restart_n),
        .start     (start),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .board_q   (board_q),
        .sol_q     (sol_q),
        .busy      (busy),
        .done      (done),
        .solved    (solved),
        .empty_cnt (empty_cnt),
        .err_cnt   (err_cnt),
        .first_err (first_err)
    );

    // Behavioural RAMs: 1-cycle read latency, garbage when not strobed.
    logic [3:0] board_mem [81];
    logic [3:0] sol_mem   [81];

    always @(posedge clka) begin
        if (rd_en && int'(rd_addr) < 81) begin
            board_q <= board_mem[int'(rd_addr)];
            sol_q   <= sol_mem[int'(rd_addr)];
        end else begin
            board_q <= 4'($urandom_range(0, 15));
            sol_q   <= 4'($urandom_range(0, 15));
        end
    end

    typedef struct {
        int solved;
        int empty;
        int err;
        int first;
    } res_t;

    typedef struct {
        int   a0;
        int   v0;
        int   a1;
        int   v1;
        res_t res;
    } vec_t;

    res_t sb_q[$];
    res_t prev;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic check_results(input string tag, input res_t e);
        chk({tag, "_solved"},    int'(solved),    e.solved);
        chk({tag, "_empty_cnt"}, int'(empty_cnt), e.empty);
        chk({tag, "_err_cnt"},   int'(err_cnt),   e.err);
        chk({tag, "_first_err"}, int'(first_err), e.first);
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 81; i++) board_mem[i] = sol_mem[i];
        if (v.a0 >= 0) board_mem[v.a0] = 4'(v.v0);
        if (v.a1 >= 0) board_mem[v.a1] = 4'(v.v1);
    endtask

    // Called at a negedge with the DUT in IDLE and start low.
    task automatic run_scan(input string tag, input res_t e, input int hold);
        res_t got;
        int   bad;
        int   dones;
        int   strobes;
        check_results({tag, "_hold_pre"}, prev);
        sb_q.push_back(e);
        start = 1'b1;
        bad = 0;
        for (int k = 0; k < 81; k++) begin
            @(negedge clka);
            if (!(rd_en && int'(rd_addr) == k && busy && !done)) bad++;
            if (k == 0) begin
                chk({tag, "_clr_empty"}, int'(empty_cnt), 0);
                chk({tag, "_clr_first"}, int'(first_err), 127);
            end
        end
        chk({tag, "_addr_trace_bad_cycles"}, bad, 0);
        @(negedge clka);
        chk({tag, "_drain_rd_en"}, int'(rd_en), 0);
        chk({tag, "_drain_busy"},  int'(busy),  1);
        chk({tag, "_drain_done"},  int'(done),  0);
        @(negedge clka);
        chk({tag, "_done_at_82"}, int'(done), 1);
        chk({tag, "_busy_at_82"}, int'(busy), 0);
        if (sb_q.size() == 0) begin
            failures++;
            checks++;
            $display("FAIL %s_scoreboard: got empty queue required entry", tag);
        end else begin
            got = sb_q.pop_front();
            check_results(tag, got);
            prev = got;
        end
        dones = 0;
        strobes = 0;
        repeat (hold) begin
            @(negedge clka);
            if (done) dones++;
            if (rd_en || busy) strobes++;
        end
        chk({tag, "_extra_done"}, dones, 0);
        chk({tag, "_rescan"}, strobes, 0);
        start = 1'b0;
        @(negedge clka);
        @(negedge clka);
        check_results({tag, "_hold_post"}, prev);
    endtask

    vec_t vecs [6];

    initial begin
        res_t rr;
        vec_t vv;
        int   n_done;
        int   n_str;

        for (int i = 0; i < 81; i++) sol_mem[i] = 4'((i % 9) + 1);

        vecs[0] = '{a0: -1, v0: 0, a1: -1, v1: 0, res: '{1, 0, 0, 127}};
        vecs[1] = '{a0: 5,  v0: 0, a1: 40, v1: 0, res: '{0, 2, 0, 127}};
        vecs[2] = '{a0: 80, v0: 3, a1: 12, v1: 1, res: '{0, 0, 2, 12}};
        vecs[3] = '{a0: 0,  v0: 0, a1: 80, v1: 0, res: '{0, 2, 0, 127}};
        vecs[4] = '{a0: 0,  v0: 2, a1: 79, v1: 0, res: '{0, 1, 1, 0}};
        vecs[5] = '{a0: 80, v0: 5, a1: -1, v1: 0, res: '{0, 0, 1, 80}};

        restart_n = 1'b0;
        start     = 1'b0;
        repeat (3) @(negedge clka);
        chk("reset_rd_en", int'(rd_en), 0);
        chk("reset_rd_addr", int'(rd_addr), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        prev = '{0, 0, 0, 127};
        check_results("reset", prev);
        restart_n = 1'b1;
        @(negedge clka);

        // Table-driven runs, back to back with the board changed between them.
        for (int v = 0; v < 6; v++) begin
            load_vec(vecs[v]);
            run_scan($sformatf("vec%0d", v), vecs[v].res, (v == 0) ? 100 : 10);
        end

        // Random board against a reference count over the memory contents.
        rr = '{1, 0, 0, 127};
        for (int i = 0; i < 81; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 15)      board_mem[i] = 4'd0;
            else if (r < 30) board_mem[i] = 4'(((i + 3) % 9) + 1);
            else             board_mem[i] = sol_mem[i];
            if (board_mem[i] == 4'd0) rr.empty++;
            else if (board_mem[i] != sol_mem[i]) begin
                rr.err++;
                if (rr.first == 127) rr.first = i;
            end
        end
        rr.solved = (rr.empty == 0 && rr.err == 0) ? 1 : 0;
        run_scan("rand", rr, 5);

        // Reset in the middle of a scan with early empties accumulated.
        load_vec(vecs[1]);
        start = 1'b1;
        repeat (31) @(negedge clka);
        chk("midscan_busy", int'(busy), 1);
        chk("midscan_empty_before_reset", int'(empty_cnt), 1);
        restart_n = 1'b0;
        start     = 1'b0;
        @(negedge clka);
        chk("rst_mid_rd_en", int'(rd_en), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        prev = '{0, 0, 0, 127};
        check_results("rst_mid", prev);
        restart_n = 1'b1;
        n_done = 0;
        n_str  = 0;
        repeat (100) begin
            @(negedge clka);
            if (done) n_done++;
            if (rd_en || busy) n_str++;
        end
        chk("rst_mid_no_done", n_done, 0);
        chk("rst_mid_no_scan", n_str, 0);
        sb_q.delete();

        vv = vecs[2];
        load_vec(vv);
        run_scan("after_reset", vv.res, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
